// File: rtl/defuzz_wavg.sv
// Weighted-average defuzzifier: four serial MAC steps, then a 35-step restoring
// divide of sum(w_i*C_i) by sum(w_i), with valid/ready handshakes on both sides.
module defuzz_wavg #(
   parameter logic signed [15:0] C_NN        = -16'sd16384,
   parameter logic signed [15:0] C_NP        = -16'sd8192,
   parameter logic signed [15:0] C_PN        = 16'sd8192,
   parameter logic signed [15:0] C_PP        = 16'sd16384,
   parameter logic signed [15:0] DEFAULT_OUT = 16'sd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        w_nn,
   input  logic [15:0]        w_np,
   input  logic [15:0]        w_pn,
   input  logic [15:0]        w_pp,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] y,
   output logic               zero_w
);

   typedef enum logic [2:0] {IDLE, MAC, CHK, DIV, DONE} state_t;

   state_t             state, state_nxt;
   logic [3:0][15:0]   wr;
   logic [1:0]         idx;
   logic [5:0]         cnt;
   logic signed [34:0] acc;
   logic [17:0]        sum_w;
   logic               sign;
   logic [34:0]        dvd;
   logic [17:0]        dvs;
   logic [17:0]        rem;
   logic [14:0]        q;

   logic [15:0]        wsel;
   logic signed [15:0] csel;
   logic signed [32:0] wx, cx, prod;
   logic signed [34:0] prod_ext;
   logic [34:0]        mag;
   logic [18:0]        rem_sh;
   logic [17:0]        diff;
   logic               ge;
   logic [15:0]        q_nxt;

   // multiply-accumulate operand selection
   always_comb begin
      wsel = wr[idx];
      unique case (idx)
         2'd0:    csel = C_NN;
         2'd1:    csel = C_NP;
         2'd2:    csel = C_PN;
         default: csel = C_PP;
      endcase
      wx       = {17'b0, wsel};
      cx       = {{17{csel[15]}}, csel};
      prod     = wx * cx;
      prod_ext = {{2{prod[32]}}, prod};
      mag      = acc[34] ? (35'd0 - acc) : acc;
   end

   // restoring divider step; the quotient never exceeds 16 bits
   always_comb begin
      rem_sh = {rem, dvd[34]};
      ge     = rem_sh >= {1'b0, dvs};
      diff   = 18'(rem_sh - {1'b0, dvs});
      q_nxt  = {q, ge};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid)        state_nxt = MAC;
         MAC:  if (idx == 2'd3)     state_nxt = CHK;
         CHK:  state_nxt = (sum_w == '0) ? DONE : DIV;
         DIV:  if (cnt == 6'd34)    state_nxt = DONE;
         DONE: if (out_ready)       state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr     <= '0;
         idx    <= '0;
         cnt    <= '0;
         acc    <= '0;
         sum_w  <= '0;
         sign   <= 1'b0;
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         q      <= '0;
         y      <= '0;
         zero_w <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               wr    <= {w_pp, w_pn, w_np, w_nn};
               acc   <= '0;
               sum_w <= '0;
               idx   <= '0;
            end
            MAC: begin
               acc   <= acc + prod_ext;
               sum_w <= sum_w + {2'b0, wsel};
               idx   <= idx + 2'd1;
            end
            CHK: begin
               if (sum_w == '0) begin
                  y      <= DEFAULT_OUT;
                  zero_w <= 1'b1;
               end else begin
                  sign <= acc[34];
                  dvd  <= mag;
                  dvs  <= sum_w;
                  rem  <= '0;
                  q    <= '0;
                  cnt  <= '0;
               end
            end
            DIV: begin
               dvd <= {dvd[33:0], 1'b0};
               rem <= ge ? diff : rem_sh[17:0];
               q   <= q_nxt[14:0];
               cnt <= cnt + 6'd1;
               if (cnt == 6'd34) begin
                  y      <= sign ? (16'd0 - q_nxt) : q_nxt;
                  zero_w <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_defuzz_wavg.sv
// Self-checking bench for defuzz_wavg: directed vector table, randomized runs
// against an arithmetic reference, plus backpressure and mid-divide reset.
module tb_defuzz_wavg;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [15:0]        w_nn = '0, w_np = '0, w_pn = '0, w_pp = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] y;
   logic               zero_w;

   int checks = 0;
   int errors = 0;

   defuzz_wavg dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .w_nn(w_nn), .w_np(w_np), .w_pn(w_pn), .w_pp(w_pp),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero_w(zero_w)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic [15:0] a, b, c, d;
      int          exp_y;
      int          exp_z;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
      end
   endtask

   // reference: plain integer arithmetic, division truncating toward zero
   function automatic void ref_model(input logic [15:0] a, b, c, d,
                                     output int ry, output int rz);
      longint wa = a, wb = b, wc = c, wd = d;
      longint acc = -16384 * wa - 8192 * wb + 8192 * wc + 16384 * wd;
      longint s = wa + wb + wc + wd;
      if (s == 0) begin
         ry = 0;
         rz = 1;
      end else begin
         ry = int'(acc / s);
         rz = 0;
      end
   endfunction

   // accept edge is E0; returns #1 after E0 with the inputs scrambled
   task automatic send(input logic [15:0] a, b, c, d);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      w_nn = a; w_np = b; w_pn = c; w_pp = d;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w_nn = 16'($urandom); w_np = 16'($urandom);
      w_pn = 16'($urandom); w_pp = 16'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) chk("out_timeout", 0, 1);
   endtask

   vec_t tbl[5];

   initial begin
      int lat, ry, rz, nobs;
      logic [15:0] ra, rb, rc, rd;

      tbl[0] = '{"single_pp",  16'h0000, 16'h0000, 16'h0000, 16'h8000, 16384,  0, 40};
      tbl[1] = '{"symmetric",  16'h4000, 16'h4000, 16'h4000, 16'h4000, 0,      0, 40};
      tbl[2] = '{"mixed",      16'h1000, 16'h0000, 16'h0000, 16'h3000, 8192,   0, 40};
      tbl[3] = '{"trunc_neg",  16'h0001, 16'h0002, 16'h0000, 16'h0000, -10922, 0, 40};
      tbl[4] = '{"all_zero",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,      1, 5};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_zero_w", int'(zero_w), 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", int'(in_ready), 1);

      foreach (tbl[i]) begin
         send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
         chk({tbl[i].name, "_busy"}, int'(in_ready), 0);
         wait_out(lat);
         chk({tbl[i].name, "_y"}, int'(y), tbl[i].exp_y);
         chk({tbl[i].name, "_zero_w"}, int'(zero_w), tbl[i].exp_z);
         chk({tbl[i].name, "_lat"}, lat, tbl[i].exp_lat);
         @(posedge clk); #1;
         chk({tbl[i].name, "_hs_valid"}, int'(out_valid), 0);
         chk({tbl[i].name, "_hs_ready"}, int'(in_ready), 1);
      end

      for (int k = 0; k < 40; k++) begin
         ra = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         rc = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         rd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         if (k % 10 == 9) begin
            ra = '0; rb = '0; rc = '0; rd = '0;
         end
         ref_model(ra, rb, rc, rd, ry, rz);
         send(ra, rb, rc, rd);
         wait_out(lat);
         chk("rand_y", int'(y), ry);
         chk("rand_zero_w", int'(zero_w), rz);
         chk("rand_lat", lat, rz ? 5 : 40);
         @(posedge clk); #1;
      end

      // backpressure: result held, in_valid ignored
      out_ready = 1'b0;
      send(16'h0000, 16'h0000, 16'h0000, 16'h8000);
      wait_out(lat);
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         w_nn = 16'hFFFF; w_np = '0; w_pn = '0; w_pp = '0;
         @(posedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_y", int'(y), 16384);
         chk("bp_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_hs_valid", int'(out_valid), 0);
      chk("bp_hs_ready", int'(in_ready), 1);

      // reset in the middle of the divide
      send(16'h1234, 16'h0000, 16'h0000, 16'h5678);
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_y", int'(y), 0);
      chk("mid_rst_zero_w", int'(zero_w), 0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 1);
      nobs = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (out_valid) nobs++;
      end
      chk("no_spurious_valid", nobs, 0);

      send(16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
      wait_out(lat);
      chk("post_rst_y", int'(y), 8192);
      chk("post_rst_lat", lat, 40);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
